// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: WB-stage branch/jump redirect FSM (IDLE/REQ/FLUSH) with fetch handshake.
// Define BR_REDIRECT_STATS_EN to compile in the saturating taken/stall statistics counters.
module branch_redirect_ctrl #(
    parameter int FLUSH_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_valid,
    input  logic [3:0]  wb_opcode,
    input  logic        wb_ir11,
    input  logic        wb_setcc,
    input  logic        branch_enable,
    input  logic [15:0] br_target,
    input  logic [15:0] jmp_target,
    input  logic        fetch_ack,
    output logic        cc_load,
    output logic        adj_sel,
    output logic        redirect_req,
    output logic [15:0] redirect_pc,
    output logic        flush,
    output logic        stall,
    output logic [15:0] stat_taken,
    output logic [15:0] stat_stall
);
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_JSR = 4'b0100;
    localparam logic [3:0] OP_JMP = 4'b1100;

    typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pc_q, pc_d;
    logic        idle, take, use_jmp;

    assign idle    = state_q == IDLE;
    assign use_jmp = (wb_opcode == OP_JMP) | ((wb_opcode == OP_JSR) & ~wb_ir11);
    // Input-derived outputs are gated by rst_n so reset clears every output at once.
    assign take    = rst_n & wb_valid & idle &
                     (((wb_opcode == OP_BR) & branch_enable) | (wb_opcode == OP_JMP) | (wb_opcode == OP_JSR));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: if (take) begin
                state_d = REQ;
                pc_d    = use_jmp ? jmp_target : br_target;
            end
            REQ: if (fetch_ack) begin
                state_d = FLUSH;
                cnt_d   = 4'(FLUSH_CYCLES - 1);
            end
            FLUSH: begin
                state_d = (cnt_q == 4'd0) ? IDLE : FLUSH;
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    assign cc_load      = rst_n & wb_valid & wb_setcc & idle;
    assign adj_sel      = rst_n & (wb_opcode == OP_JSR) & wb_ir11;
    assign redirect_req = state_q == REQ;
    assign redirect_pc  = pc_q;
    assign flush        = take | ~idle;
    assign stall        = ~idle;

`ifdef BR_REDIRECT_STATS_EN
    logic [15:0] taken_q, stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_q <= 16'h0000;
            stall_q <= 16'h0000;
        end else begin
            if (redirect_req && fetch_ack && taken_q != 16'hFFFF)
                taken_q <= taken_q + 16'd1;
            if (stall && stall_q != 16'hFFFF)
                stall_q <= stall_q + 16'd1;
        end
    end

    assign stat_taken = taken_q;
    assign stat_stall = stall_q;
`else
    assign stat_taken = 16'h0000;
    assign stat_stall = 16'h0000;
`endif
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: table-driven IDLE-decode vectors plus hand sequences for redirect timing, reset and stats.
module tb_branch_redirect_ctrl;
    logic        clk, rst_n, wb_valid, wb_ir11, wb_setcc, branch_enable, fetch_ack;
    logic [3:0]  wb_opcode;
    logic [15:0] br_target, jmp_target;
    logic        cc_load, adj_sel, redirect_req, flush, stall;
    logic [15:0] redirect_pc, stat_taken, stat_stall;

    int checks = 0;
    int errors = 0;

    branch_redirect_ctrl #(.FLUSH_CYCLES(3)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_opcode(wb_opcode),
        .wb_ir11(wb_ir11), .wb_setcc(wb_setcc), .branch_enable(branch_enable),
        .br_target(br_target), .jmp_target(jmp_target), .fetch_ack(fetch_ack),
        .cc_load(cc_load), .adj_sel(adj_sel), .redirect_req(redirect_req),
        .redirect_pc(redirect_pc), .flush(flush), .stall(stall),
        .stat_taken(stat_taken), .stat_stall(stat_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic        ir11, setcc, be;
        logic [15:0] brt, jmt;
        logic        cc, adj, take;
        logic [15:0] pc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_opcode = 4'h0; wb_ir11 = 1'b0; wb_setcc = 1'b0;
        branch_enable = 1'b0; fetch_ack = 1'b0;
    endtask

    task automatic set_in(input logic v, input logic [3:0] op, input logic ir, input logic sc,
                          input logic be, input logic [15:0] bt, input logic [15:0] jt);
        wb_valid = v; wb_opcode = op; wb_ir11 = ir; wb_setcc = sc;
        branch_enable = be; br_target = bt; jmp_target = jt;
    endtask

    int nflush, nreq, nstall;

    initial begin
        vecs[0] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'h3010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h3010};
        vecs[1] = '{1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 16'h5000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h3010};
        vecs[2] = '{1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h4000, 1'b0, 1'b0, 1'b1, 16'h4000};
        vecs[3] = '{1'b1, 4'h4, 1'b1, 1'b0, 1'b0, 16'h2222, 16'h5555, 1'b0, 1'b1, 1'b1, 16'h2222};
        vecs[4] = '{1'b1, 4'hC, 1'b1, 1'b0, 1'b0, 16'h9999, 16'h1234, 1'b0, 1'b0, 1'b1, 16'h1234};
        vecs[5] = '{1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 16'h8888, 16'h8888, 1'b1, 1'b0, 1'b0, 16'h1234};
        vecs[6] = '{1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 16'h6666, 16'h6666, 1'b0, 1'b0, 1'b0, 16'h1234};
        vecs[7] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b1, 16'h00FE, 16'hAAAA, 1'b1, 1'b0, 1'b1, 16'h00FE};
        vecs[8] = '{1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 16'h7777, 16'h7777, 1'b1, 1'b0, 1'b0, 16'h00FE};
        vecs[9] = '{1'b0, 4'h4, 1'b1, 1'b0, 1'b0, 16'h3333, 16'h3333, 1'b0, 1'b1, 1'b0, 16'h00FE};

        idle_inputs();
        br_target = 16'h0; jmp_target = 16'h0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_flush", flush, 1'b0);
        chk("reset_stall", stall, 1'b0);
        chk("reset_req", redirect_req, 1'b0);
        chk("reset_pc", redirect_pc, 16'h0000);
        chk("reset_stat_taken", stat_taken, 16'h0000);
        chk("reset_stat_stall", stat_stall, 16'h0000);
        step();
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].valid, vecs[i].op, vecs[i].ir11, vecs[i].setcc, vecs[i].be, vecs[i].brt, vecs[i].jmt);
            #1;
            chk($sformatf("v%0d_cc_load", i), cc_load, vecs[i].cc);
            chk($sformatf("v%0d_adj_sel", i), adj_sel, vecs[i].adj);
            chk($sformatf("v%0d_flush", i), flush, vecs[i].take);
            chk($sformatf("v%0d_stall", i), stall, 1'b0);
            chk($sformatf("v%0d_req_idle", i), redirect_req, 1'b0);
            step();
            wb_valid = 1'b0; wb_setcc = 1'b0;
            #1;
            chk($sformatf("v%0d_req", i), redirect_req, vecs[i].take);
            chk($sformatf("v%0d_pc", i), redirect_pc, vecs[i].pc);
            if (vecs[i].take) begin
                chk($sformatf("v%0d_req_stall", i), stall, 1'b1);
                fetch_ack = 1'b1;
                step();
                fetch_ack = 1'b0;
                #1;
                chk($sformatf("v%0d_flush_state", i), flush & stall & ~redirect_req, 1'b1);
                step();
                step();
                step();
                chk($sformatf("v%0d_back_idle", i), {flush, stall, redirect_req}, 3'b000);
            end
        end

        // Redirect timing with ack on the second REQ cycle; a JMP+setcc arrives mid-FLUSH and must be ignored.
        nflush = 0; nreq = 0; nstall = 0;
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            if (i == 0) set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'h3010, 16'h0000);
            if (i == 4) set_in(1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 16'hBEEF, 16'hDEAD);
            fetch_ack = (i == 2);
            #1;
            nflush += int'(flush);
            nreq   += int'(redirect_req);
            nstall += int'(stall);
            if (i == 4) chk("cc_load_in_flush", cc_load, 1'b0);
            step();
        end
        chk("seqA_flush_cycles", nflush, 6);
        chk("seqA_req_cycles", nreq, 2);
        chk("seqA_stall_cycles", nstall, 5);
        chk("seqA_pc", redirect_pc, 16'h3010);
        chk("seqA_idle", {flush, stall, redirect_req}, 3'b000);

        // Reset mid-REQ without ack abandons the redirect.
        set_in(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hABCD);
        step();
        idle_inputs();
        step();
        step();
        step();
        chk("seqB_held_req", redirect_req, 1'b1);
        chk("seqB_held_pc", redirect_pc, 16'hABCD);
        set_in(1'b1, 4'h4, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
        #3 rst_n = 1'b0;
        #1;
        chk("seqB_rst_req", redirect_req, 1'b0);
        chk("seqB_rst_flush_stall", {flush, stall}, 2'b00);
        chk("seqB_rst_pc", redirect_pc, 16'h0000);
        chk("seqB_rst_adj_cc", {adj_sel, cc_load}, 2'b00);
        idle_inputs();
        step();
        rst_n = 1'b1;
        step();
        chk("seqB_no_pending", {redirect_req, flush, stall}, 3'b000);
        set_in(1'b1, 4'hC, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0BEE);
        #1;
        chk("seqB_restart_flush", flush, 1'b1);
        step();
        idle_inputs();
        #1;
        chk("seqB_restart_req", redirect_req, 1'b1);
        chk("seqB_restart_pc", redirect_pc, 16'h0BEE);

        // Statistics: three taken branches with immediate ack after a fresh reset.
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        for (int b = 0; b < 3; b++) begin
            set_in(1'b1, 4'h0, 1'b0, 1'b0, 1'b1, 16'h1000 + 16'(b), 16'h0000);
            step();
            idle_inputs();
            fetch_ack = 1'b1;
            step();
            fetch_ack = 1'b0;
            step();
            step();
            step();
        end
        chk("stats_idle", stall, 1'b0);
`ifdef BR_REDIRECT_STATS_EN
        chk("stat_taken", stat_taken, 16'd3);
        chk("stat_stall", stat_stall, 16'd12);
`else
        chk("stat_taken", stat_taken, 16'h0000);
        chk("stat_stall", stat_stall, 16'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_redirect_ctrl.md
BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3, legal 1..15: number of squash cycles after a redirect is accepted.
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 wb_valid  in  1  WB-stage instruction valid.
REQ-005 wb_opcode  in  4  LC-3b opcode of WB instruction (BR=0000, JSR=0100, JMP=1100).
REQ-006 wb_ir11  in  1  IR[11] of WB instruction (1=JSR, 0=JSRR).
REQ-007 wb_setcc  in  1  WB instruction writes condition codes.
REQ-008 branch_enable  in  1  cccomp result for WB instruction.
REQ-009 br_target  in  16  PC-relative target from branch adder.
REQ-010 jmp_target  in  16  register target for JMP/JSRR.
REQ-011 fetch_ack  in  1  fetch stage accepts redirect this cycle.
REQ-012 cc_load  out  1  load enable for the CC register.
REQ-013 adj_sel  out  1  offset mux select, 0=adj9, 1=adj11.
REQ-014 redirect_req  out  1  redirect request to fetch.
REQ-015 redirect_pc  out  16  redirect target, registered.
REQ-016 flush  out  1  squash all stages younger than WB.
REQ-017 stall  out  1  hold WB and older stages.
REQ-018 stat_taken  out  16  taken-redirect count (see Configuration).
REQ-019 stat_stall  out  16  stall-cycle count (see Configuration).

Function
REQ-020 FSM states: IDLE, REQ, FLUSH; a 4-bit down-counter is used in FLUSH.
REQ-021 adj_sel = 1 iff wb_opcode==JSR and wb_ir11==1; else 0; combinational, in every state.
REQ-022 take = wb_valid & state==IDLE & ((opcode==BR & branch_enable) | opcode==JMP | opcode==JSR).
REQ-023 cc_load = wb_valid & wb_setcc & state==IDLE; never asserted in REQ or FLUSH.
REQ-024 IDLE, take=1: flush=1 same cycle; redirect_pc <= br_target for BR and JSR(ir11=1), jmp_target for JMP and JSRR; next state REQ.
REQ-025 IDLE, take=0: flush=0, stall=0, redirect_req=0; remain IDLE.
REQ-026 REQ: redirect_req=1, flush=1, stall=1; redirect_pc constant; on fetch_ack=1, load counter with FLUSH_CYCLES-1 and go to FLUSH; otherwise remain in REQ indefinitely.
REQ-027 FLUSH: flush=1, stall=1, redirect_req=0; decrement counter each cycle; on counter==0 go to IDLE; FLUSH lasts exactly FLUSH_CYCLES cycles.
REQ-028 fetch_ack outside REQ is ignored.
REQ-029 wb_valid, opcode, and branch_enable outside IDLE are ignored; a second branch cannot start until IDLE is re-entered.
REQ-030 BR with branch_enable=0 (incl. nzp=000) is not taken; no flush and no stall.
REQ-031 Minimum redirect turnaround: detect cycle + 1 REQ cycle (ack immediate) + FLUSH_CYCLES cycles.

Reset
REQ-032 rst_n=0 immediately forces state IDLE, counter 0, redirect_pc 0x0000, stat counters 0, and all outputs 0, independent of clk.
REQ-033 Reset asserted in REQ or FLUSH abandons the redirect; after release the block is in IDLE with no pending request.

Configuration
REQ-034 Macro BR_REDIRECT_STATS_EN compiles in the statistics counters.
REQ-035 With the macro defined: stat_taken increments on each REQ->FLUSH transition; stat_stall increments on each cycle with stall=1; both saturate at 0xFFFF.
REQ-036 Without the macro: stat_taken and stat_stall are constant 0x0000; ports remain present; all other behaviour is identical.

Verification
REQ-037 BR, branch_enable=1, br_target=0x3010, fetch_ack on 2nd REQ cycle, FLUSH_CYCLES=3 -> flush high 6 cycles, redirect_req high 2 cycles, redirect_pc=0x3010, then IDLE.
REQ-038 BR, branch_enable=0, wb_setcc=0 -> no flush/stall/redirect_req; cc_load=0.
REQ-039 JSRR (ir11=0), jmp_target=0x4000 -> adj_sel=0, redirect_pc=0x4000; JSR (ir11=1), br_target=0x2222 -> adj_sel=1, redirect_pc=0x2222.
REQ-040 ADD with wb_setcc=1 in IDLE -> cc_load=1 one cycle; same instruction held during FLUSH -> cc_load=0.
REQ-041 rst_n low mid-REQ with fetch_ack never given -> outputs 0 asynchronously; after release, valid JMP restarts a fresh redirect.
REQ-042 With BR_REDIRECT_STATS_EN, 3 taken branches, ack immediate, FLUSH_CYCLES=3 -> stat_taken=3, stat_stall=12; without macro both read 0x0000.
